// File: rtl/count_event_monitor.sv
// count_event_monitor
//
// Watches a loadable mod-(MAX+1) up/down counter and turns its raw count
// trace into a compact event stream. Each cycle the previous count and the
// previous load/direction controls are used to predict the current count;
// loads, wrap-arounds and illegal steps are queued in a small FIFO.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   count      counter output under observation (WIDTH bits)
//   load       counter load control, as driven to the counter
//   up_down    counter direction: 1 = up, 0 = down
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head event
//   evt_code   head code: 00 STEP_ERR, 01 LOAD, 10 WRAP_UP, 11 WRAP_DN
//   evt_value  count value captured when the head event was detected
//   wrap_cnt   running total of wrap detections, modulo 256
//   overflow   sticky: an event was dropped because the FIFO was full
module count_event_monitor #(
    parameter int WIDTH = 4,
    parameter int MAX   = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic             up_down,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [WIDTH-1:0] evt_value,
    output logic [7:0]       wrap_cnt,
    output logic             overflow
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [AW:0]      DEPTH_V = (AW+1)'(DEPTH);

    localparam logic [1:0] CODE_STEP_ERR = 2'b00;
    localparam logic [1:0] CODE_LOAD     = 2'b01;
    localparam logic [1:0] CODE_WRAP_UP  = 2'b10;
    localparam logic [1:0] CODE_WRAP_DN  = 2'b11;

    // Delayed view of the counter and its controls
    logic [WIDTH-1:0] prev_reg;
    logic             load_d_reg;
    logic             up_d_reg;
    logic             primed_reg;

    // FIFO state; pointers carry one extra bit to tell full from empty
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [1:0]       mem_code  [DEPTH];
    logic [WIDTH-1:0] mem_value [DEPTH];

    logic [7:0]       wrap_cnt_reg;
    logic             overflow_reg;

    // Classification results
    logic [WIDTH-1:0] expected_next;
    logic             evt_detect;
    logic             wrap_detect;
    logic [1:0]       code_next;

    // FIFO control
    logic [AW:0]      level;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             write_en;
    logic             drop;

    always_comb begin
        expected_next = '0;
        if (up_d_reg) begin
            expected_next = (prev_reg == MAX_V) ? '0 : prev_reg + WIDTH'(1);
        end else begin
            expected_next = (prev_reg == '0) ? MAX_V : prev_reg - WIDTH'(1);
        end
    end

    // A wrap is only a wrap when the step itself was legal, so the step
    // check sits ahead of both wrap checks.
    always_comb begin
        evt_detect  = 1'b0;
        wrap_detect = 1'b0;
        code_next   = CODE_STEP_ERR;
        if (primed_reg) begin
            if (load_d_reg) begin
                evt_detect = 1'b1;
                code_next  = CODE_LOAD;
            end else if (count != expected_next) begin
                evt_detect = 1'b1;
                code_next  = CODE_STEP_ERR;
            end else if (up_d_reg && prev_reg == MAX_V && count == '0) begin
                evt_detect  = 1'b1;
                wrap_detect = 1'b1;
                code_next   = CODE_WRAP_UP;
            end else if (!up_d_reg && prev_reg == '0 && count == MAX_V) begin
                evt_detect  = 1'b1;
                wrap_detect = 1'b1;
                code_next   = CODE_WRAP_DN;
            end
        end
    end

    assign level      = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (level == DEPTH_V);
    assign pop        = !fifo_empty && evt_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign write_en   = evt_detect && (!fifo_full || pop);
    assign drop       = evt_detect && fifo_full && !pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_reg     <= '0;
            load_d_reg   <= 1'b0;
            up_d_reg     <= 1'b0;
            primed_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            wrap_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            prev_reg   <= count;
            load_d_reg <= load;
            up_d_reg   <= up_down;
            primed_reg <= 1'b1;
            if (write_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            // Wraps are tallied even when the FIFO has to drop them.
            if (wrap_detect) begin
                wrap_cnt_reg <= wrap_cnt_reg + 8'd1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_code[wr_ptr_reg[AW-1:0]]  <= code_next;
            mem_value[wr_ptr_reg[AW-1:0]] <= count;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_empty ? 2'b00 : mem_code[rd_ptr_reg[AW-1:0]];
    assign evt_value = fifo_empty ? '0 : mem_value[rd_ptr_reg[AW-1:0]];
    assign wrap_cnt  = wrap_cnt_reg;
    assign overflow  = overflow_reg;

endmodule

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream observer of the loadable mod-(MAX+1) up/down counter. Each cycle it samples the counter's `count` output together with its `load` and `up_down` controls and classifies the transition against the expected next value. Loads, wrap-arounds and illegal steps are queued as event records in a small FIFO with a valid/ready output, and wraps are tallied in a running counter. It gives the checker and scoreboard a compact event stream instead of a raw count trace.

## Interface
- `WIDTH`, 4, width of the count and data path.
- `MAX`, 11, terminal count; the legal range is 0..MAX, and MAX must be less than 2^WIDTH.
- `DEPTH`, 4, event FIFO depth; must be a power of 2 and at least 2.
- `clk`  in  1  single clock, rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `count`  in  WIDTH  counter output under observation.
- `load`  in  1  counter load control, as driven to the counter.
- `up_down`  in  1  counter direction control: 1 = up, 0 = down.
- `evt_valid`  out  1  the FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  2  head event code: 00 STEP_ERR, 01 LOAD, 10 WRAP_UP, 11 WRAP_DN.
- `evt_value`  out  WIDTH  `count` value at the cycle the event was detected.
- `wrap_cnt`  out  8  total WRAP_UP plus WRAP_DN detections, modulo 256.
- `overflow`  out  1  sticky flag: an event was dropped because the FIFO was full.

## Operation
- Registers updated on every clock edge: `prev` <= `count`, `load_d` <= `load`, `up_d` <= `up_down`, `primed` <= 1.
- Expected next value:
  - `up_d`=1: `prev`==MAX ? 0 : `prev`+1.
  - `up_d`=0: `prev`==0 ? MAX : `prev`-1.
- Classification runs only when `primed`=1, using the current `count`. Priority order:
  1. `load_d`=1 -> LOAD, whatever the value.
  2. `count` != expected -> STEP_ERR.
  3. `up_d`=1, `prev`==MAX, `count`==0 -> WRAP_UP.
  4. `up_d`=0, `prev`==0, `count`==MAX -> WRAP_DN.
  5. Anything else is a normal step; no event.
- Each event pushes {code, `count`} into the FIFO.
- `wrap_cnt` increments on every WRAP_UP/WRAP_DN detection, even when that event is dropped. It wraps 255 -> 0.
- FIFO behaviour:
  - `evt_valid` = not empty.
  - `evt_code` and `evt_value` show the head entry; both are 0 when empty.
  - Pop occurs when `evt_valid` and `evt_ready` are both high.
  - Push when full with no pop in the same cycle: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both take effect, nothing is dropped, occupancy is unchanged.
  - Push and pop in the same cycle when empty: push only; the new entry is not bypassed to the output.
- Ordering: strict FIFO order; no reordering, no coalescing.

## Timing
- Reset (asynchronous, immediate): `primed`=0, FIFO emptied, `evt_valid`=0, `evt_code`=0, `evt_value`=0, `wrap_cnt`=0, `overflow`=0, `prev`=0, `load_d`=0, `up_d`=0.
- First cycle after reset release: no classification, since `primed`=0.
- Load sequence: `load`=1 during cycle n. The counter shows the loaded data in cycle n+1, where `load_d`=1. LOAD is detected in cycle n+1 and written at the end of n+1. `evt_valid` rises in cycle n+2 if the FIFO was empty.
- General latency: an event detected in cycle n is visible on the outputs in cycle n+1 when the FIFO was empty.
- `wrap_cnt` updates at the same edge as the corresponding FIFO write.
- `overflow` sets at the edge of the dropped push and holds until reset.
- Reset asserted mid-operation discards all queued events. Outputs go to their reset values without waiting for a clock edge.

## Test plan
- Reset, then count up 0..11 with `load`=0 and `up_down`=1 -> exactly one event, WRAP_UP with value 0, one cycle after `count`=0 is presented. `wrap_cnt`=1. No STEP_ERR.
- Load 5 with `up_down`=0, then count down to 0 and on to 11 -> LOAD with value 5, then WRAP_DN with value 11. `wrap_cnt`=1.
- Counting up, drive `count` from 3 to 7 directly -> STEP_ERR with value 7. The next step 7 -> 8 produces no event.
- DEPTH=4, `evt_ready`=0, generate 5 events -> 4 events queued and `overflow`=1. Draining returns the first 4 in order; the 5th is absent.
- FIFO full, `evt_ready`=1, and a new event in the same cycle -> occupancy stays at 4, `overflow` stays 0, and the new event appears last.
- Assert `resetn` mid-queue with 3 events pending -> `evt_valid`=0, `wrap_cnt`=0 and `overflow`=0 immediately. No event is detected in the first cycle after release.
